symbol_window: RTL and testbench

Circular history buffer for 2-bit symbol pairs, sitting directly downstream of the deperforator and upstream of the Fano decoder core. Each valid pair from the deperforator is appended at the head. The decoder walks a read pointer forward and backward through the stored pairs as it explores and backtracks the code tree. Pairs older than HIST steps behind the read pointer are retired to free space.

---
 rtl/symbol_window.sv | 99 +++++++++
 tb/tb_symbol_window.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_window.sv
// Circular history of 2-bit symbol pairs between deperforator and Fano decoder; the decoder walks rd back and forth over the window.
// Zero-latency async read at rd; writes/moves land at the edge; writes dropped when full (sticky o_ovf), illegal moves flagged on o_err next cycle.
module symbol_window #(
  parameter int ADDR_W = 10,
  parameter int HIST   = 512
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_vld,
  input  logic [1:0]      i_data,
  input  logic            i_fwd,
  input  logic            i_back,
  output logic            o_vld,
  output logic [1:0]      o_data,
  output logic            o_at_tail,
  output logic            o_full,
  output logic [ADDR_W:0] o_level,
  output logic            o_ovf,
  output logic            o_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] HIST_P  = (ADDR_W + 1)'(HIST);
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] head_q, head_d, rd_q, rd_d, tail_q, tail_d;
  logic            ovf_q, ovf_d, err_q, err_d;
  logic [1:0]      mem_q [DEPTH];

  logic [ADDR_W:0] level, rd_inc;
  logic            vld, at_tail, full, wr_en, fwd_ok, back_ok;

  assign level   = head_q - tail_q;
  assign vld     = (rd_q != head_q);
  assign at_tail = (rd_q == tail_q);
  assign full    = (level == DEPTH_P);
  assign rd_inc  = rd_q + ONE;

  always_comb begin
    head_d  = head_q;
    rd_d    = rd_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    fwd_ok  = i_fwd && !i_back && vld;
    back_ok = i_back && !i_fwd && !at_tail;
    err_d   = (i_fwd && i_back) || (i_fwd && !vld) || (i_back && at_tail);

    // Full is judged on pre-edge pointers, so a same-cycle retirement cannot admit a write.
    if (i_vld) begin
      if (!full) begin
        wr_en  = reset_n;
        head_d = head_q + ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (fwd_ok) begin
      rd_d = rd_inc;
      if ((rd_inc - tail_q) > HIST_P) begin
        tail_d = tail_q + ONE;
      end
    end else if (back_ok) begin
      rd_d = rd_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
      rd_q   <= '0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      rd_q   <= rd_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Storage is deliberately not reset; after reset it is simply unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[head_q[ADDR_W-1:0]] <= i_data;
    end
  end

  assign o_vld     = vld;
  assign o_data    = vld ? mem_q[rd_q[ADDR_W-1:0]] : 2'b00;
  assign o_at_tail = at_tail;
  assign o_full    = full;
  assign o_level   = level;
  assign o_ovf     = ovf_q;
  assign o_err     = err_q;
endmodule

// File: tb/tb_symbol_window.sv
// Bench for symbol_window: four parameterisations share one stimulus stream, each checked against a queue-free absolute-index model.
module tb_symbol_window;
  localparam int NK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, i_vld, i_fwd, i_back;
  logic [1:0] i_data;
  logic       ov[NK], oat[NK], ofl[NK], oov[NK], oer[NK];
  logic [1:0] od[NK];
  logic [4:0]  lvl0;
  logic [3:0]  lvl1, lvl2;
  logic [10:0] lvl3;

  symbol_window #(.ADDR_W(4), .HIST(4)) u0 (.clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_data(i_data),
    .i_fwd(i_fwd), .i_back(i_back), .o_vld(ov[0]), .o_data(od[0]), .o_at_tail(oat[0]), .o_full(ofl[0]),
    .o_level(lvl0), .o_ovf(oov[0]), .o_err(oer[0]));
  symbol_window #(.ADDR_W(3), .HIST(7)) u1 (.clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_data(i_data),
    .i_fwd(i_fwd), .i_back(i_back), .o_vld(ov[1]), .o_data(od[1]), .o_at_tail(oat[1]), .o_full(ofl[1]),
    .o_level(lvl1), .o_ovf(oov[1]), .o_err(oer[1]));
  symbol_window #(.ADDR_W(3), .HIST(4)) u2 (.clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_data(i_data),
    .i_fwd(i_fwd), .i_back(i_back), .o_vld(ov[2]), .o_data(od[2]), .o_at_tail(oat[2]), .o_full(ofl[2]),
    .o_level(lvl2), .o_ovf(oov[2]), .o_err(oer[2]));
  symbol_window u3 (.clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_data(i_data),
    .i_fwd(i_fwd), .i_back(i_back), .o_vld(ov[3]), .o_data(od[3]), .o_at_tail(oat[3]), .o_full(ofl[3]),
    .o_level(lvl3), .o_ovf(oov[3]), .o_err(oer[3]));

  int total = 0;
  int bad   = 0;

  // Reference model: unbounded absolute write/read/retire counts, never wrapped.
  int         md[NK] = '{16, 8, 8, 1024};
  int         mh[NK] = '{4, 7, 4, 512};
  int         m_hd[NK], m_rd[NK], m_tl[NK];
  bit         m_ov[NK], m_er[NK];
  logic [1:0] m_mem[NK][4096];

  typedef struct {
    int v; int d; int f; int b;
    int e_vld; int e_data; int e_at; int e_err; int e_lvl;
  } vec_t;
  vec_t tbl[8];

  function automatic int dut_lvl(int k);
    case (k)
      0: return int'(lvl0);
      1: return int'(lvl1);
      2: return int'(lvl2);
      default: return int'(lvl3);
    endcase
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_hd[k] = 0; m_rd[k] = 0; m_tl[k] = 0; m_ov[k] = 1'b0; m_er[k] = 1'b0;
    end
  endtask

  task automatic model_step(int v, int d, int f, int b);
    for (int k = 0; k < NK; k++) begin
      bit vl, at, fl;
      vl = (m_rd[k] != m_hd[k]);
      at = (m_rd[k] == m_tl[k]);
      fl = ((m_hd[k] - m_tl[k]) == md[k]);
      m_er[k] = ((f != 0) && (b != 0)) || ((f != 0) && !vl) || ((b != 0) && at);
      if ((f != 0) && (b == 0) && vl) begin
        m_rd[k]++;
        if (m_rd[k] - m_tl[k] > mh[k]) m_tl[k]++;
      end else if ((b != 0) && (f == 0) && !at) begin
        m_rd[k]--;
      end
      if (v != 0) begin
        if (!fl) begin
          m_mem[k][m_hd[k] % 4096] = 2'(d);
          m_hd[k]++;
        end else begin
          m_ov[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < NK; k++) begin
      int vl;
      vl = (m_rd[k] != m_hd[k]) ? 1 : 0;
      chk("vld", k, int'(ov[k]), vl);
      chk("data", k, int'(od[k]), (vl != 0) ? int'(m_mem[k][m_rd[k] % 4096]) : 0);
      chk("at_tail", k, int'(oat[k]), (m_rd[k] == m_tl[k]) ? 1 : 0);
      chk("full", k, int'(ofl[k]), ((m_hd[k] - m_tl[k]) == md[k]) ? 1 : 0);
      chk("level", k, dut_lvl(k), m_hd[k] - m_tl[k]);
      chk("ovf", k, int'(oov[k]), m_ov[k] ? 1 : 0);
      chk("err", k, int'(oer[k]), m_er[k] ? 1 : 0);
    end
  endtask

  task automatic cyc(int v, int d, int f, int b);
    i_vld = (v != 0); i_data = 2'(d); i_fwd = (f != 0); i_back = (b != 0);
    @(posedge clk);
    model_step(v, d, f, b);
    #1;
    cmp_all();
  endtask

  task automatic do_reset(int v);
    reset_n = 1'b0; i_vld = (v != 0); i_data = 2'b11; i_fwd = 1'b1; i_back = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    reset_n = 1'b1; i_vld = 1'b0; i_fwd = 1'b0;
    cmp_all();
    for (int k = 0; k < NK; k++) begin
      chk("rst_vld", k, int'(ov[k]), 0);
      chk("rst_data", k, int'(od[k]), 0);
      chk("rst_at_tail", k, int'(oat[k]), 1);
      chk("rst_full", k, int'(ofl[k]), 0);
      chk("rst_level", k, dut_lvl(k), 0);
      chk("rst_ovf", k, int'(oov[k]), 0);
      chk("rst_err", k, int'(oer[k]), 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_vld = 1'b0; i_data = 2'b00; i_fwd = 1'b0; i_back = 1'b0;
    model_reset();

    //            v  d  f  b   vld data at err lvl
    tbl[0] = '{1, 1, 0, 0,  1, 1, 1, 0, 1};
    tbl[1] = '{1, 2, 0, 0,  1, 1, 1, 0, 2};
    tbl[2] = '{1, 3, 0, 0,  1, 1, 1, 0, 3};
    tbl[3] = '{0, 0, 1, 0,  1, 2, 0, 0, 3};
    tbl[4] = '{0, 0, 1, 0,  1, 3, 0, 0, 3};
    tbl[5] = '{0, 0, 1, 0,  0, 0, 0, 0, 3};
    tbl[6] = '{0, 0, 1, 0,  0, 0, 0, 1, 3};
    tbl[7] = '{0, 0, 0, 0,  0, 0, 0, 0, 3};

    do_reset(0);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].b);
      chk("t1_vld", 0, int'(ov[0]), tbl[i].e_vld);
      chk("t1_data", 0, int'(od[0]), tbl[i].e_data);
      chk("t1_at", 0, int'(oat[0]), tbl[i].e_at);
      chk("t1_err", 0, int'(oer[0]), tbl[i].e_err);
      chk("t1_lvl", 0, dut_lvl(0), tbl[i].e_lvl);
    end

    // fwd 4 / back 4 returns to the first pair; one more back is illegal
    do_reset(0);
    for (int i = 0; i < 5; i++) cyc(1, (i + 1) % 4, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("t2_data", 0, int'(od[0]), 1);
    chk("t2_at", 0, int'(oat[0]), 1);
    cyc(0, 0, 0, 1);
    chk("t2_err", 0, int'(oer[0]), 1);
    chk("t2_data_kept", 0, int'(od[0]), 1);

    // retention window of 4 behind rd
    do_reset(0);
    for (int i = 0; i < 10; i++) cyc(1, i % 4, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("t3_lvl", 0, dut_lvl(0), 8);
    chk("t3_data", 0, int'(od[0]), 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      chk("t3_back_err", 0, int'(oer[0]), 0);
    end
    chk("t3_at", 0, int'(oat[0]), 1);
    chk("t3_data_tail", 0, int'(od[0]), 2);
    cyc(0, 0, 0, 1);
    chk("t3_err", 0, int'(oer[0]), 1);

    // fill and overflow on the depth-8, HIST=7 instance
    do_reset(0);
    for (int i = 0; i < 8; i++) cyc(1, i % 4, 0, 0);
    chk("t4_full", 1, int'(ofl[1]), 1);
    chk("t4_lvl", 1, dut_lvl(1), 8);
    chk("t4_ovf0", 1, int'(oov[1]), 0);
    cyc(1, 3, 0, 0);
    chk("t4_ovf", 1, int'(oov[1]), 1);
    chk("t4_lvl9", 1, dut_lvl(1), 8);
    for (int i = 0; i < 7; i++) begin
      chk("t4_walk", 1, int'(od[1]), i % 4);
      cyc(0, 0, 1, 0);
    end
    chk("t4_last", 1, int'(od[1]), 3);

    do_reset(0);
    for (int i = 0; i < 8; i++) cyc(1, i % 4, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    chk("t4b_ovf0", 1, int'(oov[1]), 0);
    cyc(1, 2, 1, 0);
    chk("t4b_ovf", 1, int'(oov[1]), 1);
    chk("t4b_lvl", 1, dut_lvl(1), 7);
    chk("t4b_full", 1, int'(ofl[1]), 0);
    chk("t4b_vld", 1, int'(ov[1]), 0);

    // streaming across many pointer wraps on the depth-8, HIST=4 instance
    do_reset(0);
    cyc(1, 0, 0, 0);
    for (int i = 1; i < 100; i++) begin
      chk("t5_vld", 2, int'(ov[2]), 1);
      chk("t5_data", 2, int'(od[2]), (i - 1) % 4);
      cyc(1, i % 4, 1, 0);
    end
    chk("t5_data_end", 2, int'(od[2]), 3);
    cyc(0, 0, 1, 0);
    chk("t5_vld_end", 2, int'(ov[2]), 0);
    chk("t5_ovf", 2, int'(oov[2]), 0);

    // simultaneous requests, then reset in the middle of traffic
    do_reset(0);
    for (int i = 1; i < 4; i++) cyc(1, i, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    chk("t6_err", 0, int'(oer[0]), 1);
    chk("t6_lvl", 0, dut_lvl(0), 3);
    chk("t6_data", 0, int'(od[0]), 2);
    chk("t6_at", 0, int'(oat[0]), 0);
    cyc(0, 0, 0, 0);
    chk("t6_err_pulse", 0, int'(oer[0]), 0);
    for (int i = 0; i < 9; i++) cyc(1, i % 4, 0, 0);
    chk("t6_ovf_set", 1, int'(oov[1]), 1);
    do_reset(1);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(int'($urandom_range(0, 1)));
      end else begin
        cyc(($urandom_range(0, 99) < 60) ? 1 : 0, int'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 45) ? 1 : 0, ($urandom_range(0, 99) < 30) ? 1 : 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
